// File: rtl/in_stream_arbiter_pkg.sv
// Shared definitions for the IN-stream round-robin arbiter.
package in_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_SRC_MAX   = 8;
  localparam int unsigned BURST_MAX_MAX = 64;

endpackage

// File: rtl/in_stream_arbiter_rr_picker.sv
// Combinational round-robin priority picker: first requester at or above
// the pointer, wrapping around.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_sel,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int unsigned w_dist;
  int unsigned w_best_dist;
  logic [IW-1:0] w_best;
  logic w_found;

  // Pick the requester with the smallest wrapped distance from the pointer.
  always_comb begin
    w_found     = 1'b0;
    w_best      = '0;
    w_best_dist = N;
    w_dist      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_dist = (k + N - 32'(i_ptr)) % N;
      if (i_req[k] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = IW'(k);
        w_found     = 1'b1;
      end
    end
  end

  // Expand the chosen index to a one-hot select.
  always_comb begin
    o_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_sel[k] = w_found && (w_best == IW'(k));
    end
  end

  assign o_idx = w_best;
  assign o_any = w_found;

endmodule

// File: rtl/in_stream_arbiter.sv
// Round-robin arbiter sharing the usb_cdc IN byte stream between sources,
// one burst per grant, with a one-stage registered output buffer.
module in_stream_arbiter
  import in_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned BURST_MAX    = 8,
  parameter int unsigned HOLD_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [8*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  logic [NUM_SRC-1:0]   src_last_i,
  output logic [NUM_SRC-1:0]   src_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_SRC-1:0]   grant_o
);

  if (NUM_SRC < 2 || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
    $error("in_stream_arbiter: NUM_SRC out of range");
  end
  if (BURST_MAX < 1 || BURST_MAX > BURST_MAX_MAX) begin : g_bad_burst_max
    $error("in_stream_arbiter: BURST_MAX out of range");
  end

  localparam int unsigned PW = $clog2(NUM_SRC);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned SW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam bit            TIMEOUT_EN = (HOLD_TIMEOUT != 0);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] IDX_LAST   = PW'(NUM_SRC - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [NUM_SRC-1:0] r_grant;
  logic [PW-1:0]      r_gidx;
  logic [PW-1:0]      r_ptr;
  logic [BW-1:0]      r_burst;
  logic [SW-1:0]      r_stall;
  logic [7:0]         r_data;
  logic               r_valid;

  logic [NUM_SRC-1:0] w_pick_sel;
  logic [PW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic [7:0]         w_byte;
  logic               w_valid_g;
  logic               w_last_g;
  logic               w_ready;
  logic               w_xfer;
  logic               w_start;
  logic               w_exit;

  rr_picker #(
    .N  (NUM_SRC),
    .IW (PW)
  ) u_picker (
    .i_req (src_valid_i),
    .i_ptr (r_ptr),
    .o_sel (w_pick_sel),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Route the granted source's byte through the one-hot grant mask.
  always_comb begin
    w_byte = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (r_grant[k]) begin
        w_byte = w_byte | src_data_i[8*k +: 8];
      end
    end
  end

  assign w_valid_g   = |(src_valid_i & r_grant);
  assign w_last_g    = |(src_last_i & r_grant);
  assign w_ready     = (r_state == BUSY) && (!r_valid || in_ready_i);
  assign src_ready_o = w_ready ? r_grant : '0;
  assign w_xfer      = w_valid_g && w_ready;

  // Next-state logic: grant on any request, release on last/burst limit/stall timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_xfer && (w_last_g || (r_burst == BURST_LAST))) begin
          w_exit = 1'b1;
        end else if (TIMEOUT_EN && !w_valid_g && (r_stall == STALL_LAST)) begin
          w_exit = 1'b1;
        end
        if (w_exit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, round-robin pointer and burst/stall counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
      r_stall <= '0;
    end else if (w_start) begin
      r_grant <= w_pick_sel;
      r_gidx  <= w_pick_idx;
    end else if (w_exit) begin
      r_grant <= '0;
      r_burst <= '0;
      r_stall <= '0;
      r_ptr   <= (r_gidx == IDX_LAST) ? '0 : r_gidx + 1'b1;
    end else if (r_state == BUSY) begin
      if (w_xfer) begin
        r_burst <= r_burst + 1'b1;
      end
      // A source presenting data is not stalled, even while back-pressured.
      if (w_valid_g) begin
        r_stall <= '0;
      end else if (TIMEOUT_EN) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  // Output buffer: load on transfer, drain on downstream ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_byte;
    end else if (in_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign in_data_o  = r_data;
  assign in_valid_o = r_valid;
  assign grant_o    = r_grant;

endmodule

// File: tb/tb_in_stream_arbiter.sv
// Self-checking bench for in_stream_arbiter with a burst-level reference model.
module tb_in_stream_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned BMAX = 8;
  localparam int unsigned HT   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   grant;

  always #5 clk = ~clk;

  in_stream_arbiter #(
    .NUM_SRC      (N),
    .BURST_MAX    (BMAX),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_last_i  (src_last),
    .src_ready_o (src_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .grant_o     (grant)
  );

  typedef struct {
    int src;
    int len;
  } burst_t;

  logic [7:0] q_data [N][$];
  bit         q_last [N][$];
  logic [7:0] exp_q [$];
  burst_t     exp_b [$];

  bit [N-1:0] en;
  bit         rnd_ready;
  int         checks = 0;
  int         errors = 0;
  int         m_ptr = 0;
  int         cyc = 0;
  int         first_x = -1;
  int         last_x = -1;

  logic [N-1:0] s_grant, s_valid;
  logic         s_iv, s_ir;
  logic [7:0]   s_id;
  bit           prev_stall = 0;
  logic [7:0]   prev_data = '0;
  bit           in_burst = 0;
  int           b_src = 0;
  int           b_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input bit l);
    q_data[k].push_back(d);
    q_last[k].push_back(l);
  endtask

  // Sources present the head of their queue whenever enabled and non-empty.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (en[k] && q_data[k].size() > 0) begin
        src_valid[k]       = 1'b1;
        src_data[8*k +: 8] = q_data[k][0];
        src_last[k]        = q_last[k][0];
      end else begin
        src_valid[k]       = 1'b0;
        src_data[8*k +: 8] = 8'h00;
        src_last[k]        = 1'b0;
      end
    end
  endtask

  // Reference: sources stay valid while they hold data, so grants follow
  // round-robin order; a grant ends on last, BURST_MAX bytes, or when the
  // source runs dry (stall timeout).
  task automatic model_run();
    int  pos [N];
    int  g, len;
    bit  lastb, done;
    for (int k = 0; k < N; k++) pos[k] = 0;
    done = 0;
    while (!done) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (g < 0 && pos[k] < q_data[k].size()) g = k;
      end
      if (g < 0) begin
        done = 1;
      end else begin
        len = 0;
        do begin
          exp_q.push_back(q_data[g][pos[g]]);
          lastb = q_last[g][pos[g]];
          pos[g]++;
          len++;
        end while (!lastb && len < BMAX && pos[g] < q_data[g].size());
        exp_b.push_back('{g, len});
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  // One clock: sample at negedge, check the stream, then update drivers after posedge.
  task automatic cycle();
    logic [N-1:0] xfer;
    @(negedge clk);
    s_grant = grant;
    s_valid = src_valid;
    s_iv    = in_valid;
    s_ir    = in_ready;
    s_id    = in_data;
    xfer    = src_valid & src_ready;
    if (rst) begin
      in_burst   = 0;
      prev_stall = 0;
      xfer       = '0;
    end else begin
      chk("ready_outside_grant", 32'(src_ready & ~grant), 0);
      if (prev_stall) begin
        chk("bp_hold_valid", 32'(s_iv), 1);
        chk("bp_hold_data", 32'(s_id), 32'(prev_data));
      end
      prev_stall = s_iv && !s_ir;
      prev_data  = s_id;
      if (s_iv && s_ir) begin
        if (exp_q.size() == 0) chk("out_byte_unexpected", 32'(s_id), 32'h100);
        else chk("out_byte", 32'(s_id), 32'(exp_q.pop_front()));
      end
      if (|xfer) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (s_grant != '0) begin
        if (!in_burst) begin
          in_burst = 1;
          b_len    = 0;
          chk("grant_onehot", 32'($onehot(s_grant)), 1);
          for (int k = 0; k < N; k++) if (s_grant[k]) b_src = k;
        end
        if (|xfer) b_len++;
      end else if (in_burst) begin
        in_burst = 0;
        if (exp_b.size() == 0) begin
          chk("burst_unexpected", 32'(b_src), 32'hFFFF);
        end else begin
          burst_t e;
          e = exp_b.pop_front();
          chk("burst_src", 32'(b_src), 32'(e.src));
          chk("burst_len", 32'(b_len), 32'(e.len));
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (xfer[k]) begin
        void'(q_data[k].pop_front());
        void'(q_last[k].pop_front());
      end
    end
    if (rnd_ready) in_ready = ($urandom_range(9, 0) < 7);
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    int pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < budget) begin
      pend = exp_q.size() + int'(in_valid) + int'(grant != '0);
      for (int k = 0; k < N; k++) pend += q_data[k].size();
      if (pend != 0) begin
        cycle();
        n++;
      end
    end
    cycle();
    chk("cycles_within_budget", 32'(n >= budget), 0);
    chk("all_bytes_out", 32'(exp_q.size()), 0);
    chk("all_bursts_seen", 32'(exp_b.size()), 0);
  endtask

  initial begin
    bit ok;
    int stalls;
    bit seen;

    // Reset held with every source valid.
    rst = 1'b1;
    in_ready = 1'b1;
    rnd_ready = 0;
    en = '1;
    src_data = '0;
    src_valid = '0;
    src_last = '0;
    for (int i = 0; i < 6; i++) push(0, 8'(8'h01 + i), (i == 2) || (i == 5));
    for (int i = 0; i < 3; i++) push(1, 8'(8'h11 + i), (i == 2));
    drive();
    repeat (3) cycle();
    chk("rst_in_valid", 32'(in_valid), 0);
    chk("rst_in_data", 32'(in_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_src_ready", 32'(src_ready), 0);

    // Release: grant one cycle later, byte out the cycle after; 3+3+3 bursts.
    rst = 1'b0;
    m_ptr = 0;
    model_run();
    first_x = -1;
    cycle();
    chk("arb_grant_c1", 32'(grant), 32'h1);
    chk("arb_ready_c1", 32'(src_ready), 32'h1);
    cycle();
    chk("arb_valid_c2", 32'(in_valid), 1);
    chk("arb_data_c2", 32'(in_data), 32'h01);
    run_until_done(200);
    chk("burst_span_one_gap", 32'(last_x - first_x + 1), 11);

    // Source 0 never marks last: released after BURST_MAX bytes.
    for (int i = 0; i < 16; i++) push(0, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 4; i++) push(1, 8'(8'hA0 + i), (i == 1) || (i == 3));
    model_run();
    run_until_done(200);

    // Downstream back-pressure for 5 cycles mid-burst.
    for (int i = 0; i < 6; i++) push(0, 8'(8'h21 + i), (i == 5));
    model_run();
    drive();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (q_data[0].size() == 3) begin
        ok = 1;
        break;
      end
    end
    chk("bp_reached_mid_burst", 32'(ok), 1);
    in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_src_ready", 32'(src_ready), 0);
      chk("bp_grant_held", 32'(grant), 32'h1);
    end
    in_ready = 1'b1;
    run_until_done(100);

    // Source runs dry without last: released on the 16th stalled cycle.
    for (int i = 0; i < 3; i++) push(0, 8'(8'h31 + i), 1'b0);
    model_run();
    drive();
    stalls = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (s_grant != '0) seen = 1;
      if (seen && s_grant != '0 && (s_valid & s_grant) == '0) stalls++;
      if (seen && s_grant == '0) break;
    end
    chk("timeout_released", 32'(seen && s_grant == '0), 1);
    chk("timeout_stall_cycles", 32'(stalls), HT);
    // Pointer advanced past source 0, so source 1 goes first.
    push(0, 8'h41, 1'b1);
    push(1, 8'h42, 1'b1);
    model_run();
    run_until_done(100);

    // Valid returns after 15 stalled cycles: transfer, grant kept.
    push(0, 8'h51, 1'b0);
    push(0, 8'h52, 1'b0);
    push(0, 8'h53, 1'b1);
    model_run();
    drive();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (q_data[0].size() == 2) begin
        ok = 1;
        break;
      end
    end
    chk("stall15_first_byte", 32'(ok), 1);
    en[0] = 1'b0;
    drive();
    repeat (15) cycle();
    chk("stall15_grant_held", 32'(grant), 32'h1);
    en[0] = 1'b1;
    drive();
    cycle();
    chk("stall15_transfer", 32'(q_data[0].size()), 1);
    chk("stall15_grant_kept", 32'(grant), 32'h1);
    run_until_done(100);

    // Reset pulse during BUSY with a byte buffered.
    push(0, 8'h71, 1'b0);
    push(0, 8'h72, 1'b0);
    push(0, 8'h73, 1'b1);
    in_ready = 1'b0;
    drive();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (in_valid) begin
        ok = 1;
        break;
      end
    end
    chk("rst_pulse_buffered", 32'(ok), 1);
    rst = 1'b1;
    #1;
    chk("rst_pulse_in_valid", 32'(in_valid), 0);
    chk("rst_pulse_grant", 32'(grant), 0);
    chk("rst_pulse_src_ready", 32'(src_ready), 0);
    for (int k = 0; k < N; k++) begin
      q_data[k].delete();
      q_last[k].delete();
    end
    exp_q.delete();
    exp_b.delete();
    push(0, 8'h81, 1'b1);
    push(1, 8'h82, 1'b1);
    drive();
    cycle();
    rst = 1'b0;
    in_ready = 1'b1;
    m_ptr = 0;
    model_run();
    cycle();
    chk("rst_pulse_ptr_zero", 32'(grant), 32'h1);
    run_until_done(100);

    // Randomized bursts with random downstream back-pressure.
    rnd_ready = 1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        int nb;
        nb = $urandom_range(3, 1);
        for (int b = 0; b < nb; b++) begin
          int len;
          len = $urandom_range(12, 1);
          for (int i = 0; i < len; i++) push(k, 8'($urandom), (i == len - 1));
        end
      end
      model_run();
      run_until_done(3000);
    end
    rnd_ready = 0;
    in_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
